// File: rtl/multiword_addsub_seq.sv
// Wide two's-complement add/subtract built from one SIZE-bit stage, iterated
// over WORDS cycles with the carry held in a register between words.
module multiword_addsub_seq #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE*WORDS-1:0] op_a,
  input  logic [SIZE*WORDS-1:0] op_b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE*WORDS-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W  = SIZE * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_out_q, carry_out_d;
  logic            overflow_q, overflow_d;

  logic [SIZE-1:0] a_word;
  logic [SIZE-1:0] b_word;
  logic [SIZE:0]   word_sum;
  logic            b_eff_msb;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    a_word = '0;
    b_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        a_word = a_q[i*SIZE +: SIZE];
        b_word = b_q[i*SIZE +: SIZE];
      end
    end

    // Inverting B and seeding the carry with sub forms A + ~B + 1 for subtract.
    word_sum  = {1'b0, a_word} + {1'b0, b_word ^ {SIZE{sub_q}}} + {{SIZE{1'b0}}, carry_q};
    b_eff_msb = b_word[SIZE-1] ^ sub_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) begin
            result_d[i*SIZE +: SIZE] = word_sum[SIZE-1:0];
          end
        end
        carry_d = word_sum[SIZE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          // Signed overflow: effective operand signs agree but the result sign differs.
          carry_out_d = word_sum[SIZE];
          overflow_d  = (a_word[SIZE-1] == b_eff_msb) && (word_sum[SIZE-1] != a_word[SIZE-1]);
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Scoreboard bench for multiword_addsub_seq: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever a result is consumed.
module tb_multiword_addsub_seq;

  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  multiword_addsub_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every consumed result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got 0x%0h want none", result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("result", 32'(result), 32'(e.r));
        checkOutput("carry_out", 32'(carry_out), 32'(e.c));
        checkOutput("overflow", 32'(overflow), 32'(e.o));
      end
    end
  end

  // Reference: 17-bit unsigned sum for carry, signed integer range for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W:0] full;
    int sr;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      e.c  = full[W];
      sr   = int'($signed(a)) + int'($signed(b));
    end else begin
      full = {1'b0, a} - {1'b0, b};
      e.c  = (a >= b);
      sr   = int'($signed(a)) - int'($signed(b));
    end
    e.r = full[W-1:0];
    e.o = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  // Presents one operation and returns once it has been accepted (accept cycle in acc).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input exp_t e, input bit keep_valid, output int acc);
    int n;
    sb_q.push_back(e);
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    n = 0;
    acc = -1;
    while (n < 50) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    acc = cyc;
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (sb_q.size() == 0 && in_ready) break;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got pending=%0d want 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int n;
    int acc_prev;
    logic [W-1:0] ra [3];
    logic [W-1:0] rb [3];
    logic         rs [3];

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_result", 32'(result), 0);
    checkOutput("rst_carry_out", 32'(carry_out), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    @(posedge clk);
    #1;

    // Basic add with latency measured from the acceptance edge.
    applyStimulus(16'h1234, 16'h0FFF, 1'b0, '{r: 16'h2233, c: 1'b0, o: 1'b0}, 1'b0, acc);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    checkOutput("latency", 32'(n), 32'(WORDS + 1));
    drain();

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, '{r: 16'h0000, c: 1'b1, o: 1'b0}, 1'b0, acc);
    drain();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, '{r: 16'h8000, c: 1'b0, o: 1'b1}, 1'b0, acc);
    drain();
    applyStimulus(16'h0005, 16'h0007, 1'b1, '{r: 16'hFFFE, c: 1'b0, o: 1'b0}, 1'b0, acc);
    drain();
    applyStimulus(16'h8000, 16'h0001, 1'b1, '{r: 16'h7FFF, c: 1'b1, o: 1'b1}, 1'b0, acc);
    drain();
    applyStimulus(16'h1234, 16'h1234, 1'b1, '{r: 16'h0000, c: 1'b1, o: 1'b0}, 1'b0, acc);
    drain();

    // Backpressure: result must hold and a stray request must be ignored.
    out_ready = 1'b0;
    applyStimulus(16'h8000, 16'h8000, 1'b0, '{r: 16'h0000, c: 1'b1, o: 1'b1}, 1'b0, acc);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    checkOutput("bp_reach_done", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(out_valid), 1);
      checkOutput("bp_result", 32'(result), 32'h0000);
      checkOutput("bp_carry_out", 32'(carry_out), 1);
      checkOutput("bp_overflow", 32'(overflow), 1);
      checkOutput("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      if (k == 2) begin
        op_a     = 16'h1111;
        op_b     = 16'h1111;
        sub      = 1'b0;
        in_valid = 1'b1;
      end
      if (k == 4) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_after_in_ready", 32'(in_ready), 1);
    checkOutput("bp_after_out_valid", 32'(out_valid), 0);
    drain();

    // Reset on the second RUN cycle discards the operation and its carry.
    op_a     = 16'hFFFF;
    op_b     = 16'hFFFF;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_in_ready", 32'(in_ready), 1);
    checkOutput("abort_out_valid", 32'(out_valid), 0);
    checkOutput("abort_result", 32'(result), 0);
    @(posedge clk);
    #1;
    applyStimulus(16'h0001, 16'h0001, 1'b0, '{r: 16'h0002, c: 1'b0, o: 1'b0}, 1'b0, acc);
    drain();

    // Back-to-back with in_valid held high: one acceptance every WORDS+2 cycles.
    for (int i = 0; i < 3; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rs[i] = 1'($urandom_range(0, 1));
    end
    acc_prev = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ra[i], rb[i], rs[i], model(ra[i], rb[i], rs[i]), 1'b1, acc);
      if (i > 0) checkOutput("b2b_spacing", 32'(acc - acc_prev), 32'(WORDS + 2));
      acc_prev = acc;
    end
    in_valid = 1'b0;
    drain();

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
